// File: rtl/modulo_iter.sv
// modulo_iter -- iterative unsigned remainder (x mod z) by restoring
// shift-subtract, one quotient bit per clock.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (x_in dividend, z_in modulus)
//   out_valid / out_ready result handshake (rem_out, div_zero)
//   busy                  FSM is not in IDLE
//
// Parameter W: operand/result width, even and >= 4.
// Optional macro MODULO_ITER_FASTPATH_EN: resolve x < z, z == 1 and x == z
// in one cycle instead of W iterations.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready = 1
// CALC  | shift-subtract iterations (or one-cycle resolve of special cases)
// HOLD  | result presented, waiting for out_ready
module modulo_iter #(
   parameter int W = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] x_in,
   input  logic [W-1:0] z_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] rem_out,
   output logic         div_zero,
   output logic         busy
);

   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

   state_t          state, state_nxt;
   logic [W:0]      r;
   logic [W:0]      t;
   logic [W:0]      r_step;
   logic [W-1:0]    xs;
   logic [W-1:0]    zs;
   logic [CW-1:0]   cnt;
   logic            dz_q, fp_lt_q, fp_z_q;
   logic            fp_lt_nxt, fp_z_nxt;
   logic            accept, early, last;

   assign accept    = in_valid && in_ready;
   assign in_ready  = (state == IDLE) && !reset;
   assign out_valid = (state == HOLD);
   assign busy      = (state != IDLE);

   // One restoring step: r stays below z, so t < 2z and fits in W+1 bits.
   assign t      = {r[W-1:0], xs[W-1]};
   assign r_step = (t >= {1'b0, zs}) ? (t - {1'b0, zs}) : t;

   // Down-counter loaded with W at accept; terminal count at 1 marks the
   // W-th iteration.
   assign last  = (cnt == CW'(1));
   assign early = dz_q || fp_lt_q || fp_z_q;

`ifdef MODULO_ITER_FASTPATH_EN
   // z == 0 takes priority over the fast cases (x == z == 0 is a div-zero).
   assign fp_lt_nxt = (z_in != '0) && (x_in < z_in);
   assign fp_z_nxt  = (z_in != '0) && ((z_in == W'(1)) || (x_in == z_in));
`else
   assign fp_lt_nxt = 1'b0;
   assign fp_z_nxt  = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (early || last) state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Special cases are flagged at accept and resolved on the first CALC
   // edge, so their result appears one edge after the accepting edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r        <= '0;
         xs       <= '0;
         zs       <= '0;
         cnt      <= '0;
         dz_q     <= 1'b0;
         fp_lt_q  <= 1'b0;
         fp_z_q   <= 1'b0;
         rem_out  <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  r       <= '0;
                  xs      <= x_in;
                  zs      <= z_in;
                  cnt     <= CW'(W);
                  dz_q    <= (z_in == '0);
                  fp_lt_q <= fp_lt_nxt;
                  fp_z_q  <= fp_z_nxt;
               end
            end
            CALC: begin
               if (dz_q) begin
                  rem_out  <= xs;
                  div_zero <= 1'b1;
               end else if (fp_lt_q) begin
                  rem_out  <= xs;
                  div_zero <= 1'b0;
               end else if (fp_z_q) begin
                  rem_out  <= '0;
                  div_zero <= 1'b0;
               end else begin
                  r   <= r_step;
                  xs  <= xs << 1;
                  cnt <= cnt - CW'(1);
                  if (last) begin
                     rem_out  <= r_step[W-1:0];
                     div_zero <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_modulo_iter.sv
// Testbench for modulo_iter: directed corner cases plus randomized operand
// pairs, checked against a plain-arithmetic reference (x % z, latency rule).
module tb_modulo_iter;

   localparam int W = 64;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] x_in = '0;
   logic [W-1:0] z_in = '0;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] rem_out;
   logic         div_zero;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   modulo_iter #(.W(W)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .z_in      (z_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rem_out   (rem_out),
      .div_zero  (div_zero),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_rem(input logic [W-1:0] x, input logic [W-1:0] z);
      return (z == '0) ? x : (x % z);
   endfunction

   function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] z);
      if (z == '0) return 1;
`ifdef MODULO_ITER_FASTPATH_EN
      if ((x < z) || (z == 1) || (x == z)) return 1;
`endif
      return W;
   endfunction

   function automatic logic [W-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Enter and leave at a negedge. Junk is driven on the inputs while the
   // operation is in flight to show it is ignored.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] z,
                         input int hold, input string tag);
      logic [W-1:0] er;
      int           el;
      int           lat;
      logic         got;
      er = ref_rem(x, z);
      el = ref_lat(x, z);
      check({tag, "_rdy"}, 64'(in_ready), 64'd1);
      x_in = x; z_in = z; in_valid = 1'b1;
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'($urandom_range(0, 1));
      x_in = rnd64(); z_in = rnd64();
      lat = 0; got = 1'b0;
      while (!got && lat < 200) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
         if (out_valid) got = 1'b1;
         else begin
            in_valid  = 1'($urandom_range(0, 1));
            x_in      = rnd64();
            z_in      = rnd64();
            out_ready = 1'($urandom_range(0, 1));
         end
      end
      if (!got) lat = 999;
      check({tag, "_lat"}, 64'(lat), 64'(el));
      check({tag, "_rem"}, rem_out, er);
      check({tag, "_dz"}, 64'(div_zero), 64'(z == '0));
      check({tag, "_rdy_hold"}, 64'(in_ready), 64'd0);
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'($urandom_range(0, 1));
         @(posedge clock);
         @(negedge clock);
         check({tag, "_hold_v"}, 64'(out_valid), 64'd1);
         check({tag, "_hold_rem"}, rem_out, er);
         check({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({tag, "_post_v"}, 64'(out_valid), 64'd0);
      check({tag, "_post_rdy"}, 64'(in_ready), 64'd1);
      check({tag, "_post_busy"}, 64'(busy), 64'd0);
      check({tag, "_post_rem"}, rem_out, er);
   endtask

   initial begin
      logic [W-1:0] x, z;
      logic         seen;

      @(negedge clock);
      check("rst_rdy", 64'(in_ready), 64'd0);
      check("rst_v", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rem", rem_out, 64'd0);
      check("rst_dz", 64'(div_zero), 64'd0);
      in_valid = 1'b1;
      @(negedge clock);
      check("rst_no_accept", 64'(busy), 64'd0);
      in_valid = 1'b0;
      reset = 1'b0;
      @(negedge clock);

      run_op(64'd100, 64'd7, 0, "d100_7");
      run_op({W{1'b1}}, 64'h1_0000_0000, 1, "dmax_2p32");
      run_op({W{1'b1}}, {W{1'b1}}, 0, "dmax_max");
      run_op(64'd5, 64'd0, 0, "d5_0");
      run_op(64'd3, 64'd10, 0, "d3_10");
      run_op(64'd1000, 64'd9, 5, "d1000_9");
      run_op(64'h1234_5678_9abc_def0, 64'd1, 0, "dz1");
      run_op(64'hdead_beef, 64'hdead_beef, 0, "dxeqz");
      run_op(64'd0, 64'd0, 0, "d0_0");
      run_op({W{1'b1}}, 64'd2, 0, "dmax_2");

      // Reset during iteration 20 of 100 mod 7.
      x_in = 64'd100; z_in = 64'd7; in_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (19) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_v", 64'(out_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_rdy", 64'(in_ready), 64'd0);
      check("mid_rst_rem", rem_out, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      seen = 1'b0;
      repeat (80) begin
         @(negedge clock);
         seen |= out_valid;
      end
      check("mid_rst_no_result", 64'(seen), 64'd0);
      run_op(64'd100, 64'd7, 0, "after_rst");

      for (int n = 0; n < 30; n++) begin
         x = rnd64();
         case ($urandom_range(0, 4))
            0: z = 64'($urandom_range(1, 20));
            1: z = rnd64();
            2: z = rnd64() >> $urandom_range(1, 63);
            3: z = x;
            default: begin
               z = rnd64() >> $urandom_range(0, 30);
               x = x >> $urandom_range(0, 63);
            end
         endcase
         run_op(x, z, $urandom_range(0, 3), "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
